// File: rtl/f1_pkg.sv
// Shared definitions for the F1 start-light sequencer: state encoding and
// default sizing used by the top level and the hold-delay counter.
package f1_pkg;

  // Default number of lights in the gantry and width of the hold delay.
  localparam int F1_N_LIGHTS = 8;
  localparam int F1_DW       = 8;

  // Sequencer states. IDLE waits for a trigger, FILL lights one lamp per
  // tick, HOLD keeps every lamp on until the hold counter expires.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } f1_state_t;

endpackage : f1_pkg

// File: rtl/f1_delay_counter.sv
// Hold-delay counter for the start-light sequencer. Loads a value, then
// counts down by one on each enabled edge and parks at zero; it never wraps.
module f1_delay_counter
  import f1_pkg::*;
#(
  parameter int DW = F1_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_value,
  input  logic          en,
  output logic          zero
);

  logic [DW-1:0] count;

  // Load has priority over counting; a zero count simply holds.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge value of its neighbours.
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - DW'(1);
    end
  end

  assign zero = (count == '0);

endmodule : f1_delay_counter

// File: rtl/f1_light_seq.sv
// F1 start-light sequencer. On a trigger the lights fill LSB to MSB one per
// enabled tick, stay all-on for delay_q+1 further ticks, then go dark with a
// one-cycle go pulse. Loop mode restarts the fill instead of idling, and
// abort cancels the sequence from any state.
module f1_light_seq
  import f1_pkg::*;
#(
  parameter int N_LIGHTS = F1_N_LIGHTS,
  parameter int DW       = F1_DW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                trigger,
  input  logic                abort,
  input  logic                loop,
  input  logic [DW-1:0]       delay_in,
  output logic [N_LIGHTS-1:0] data_out,
  output logic                busy,
  output logic                go
);

  f1_state_t           state;
  f1_state_t           state_next;
  logic [N_LIGHTS-1:0] data_next;
  logic                go_next;
  logic [DW-1:0]       delay_q;
  logic [DW-1:0]       delay_next;
  logic                cnt_load;
  logic                cnt_en;
  logic                cnt_zero;

  // The hold counter is loaded with the latched delay when the pattern
  // reaches all-ones and counts only on HOLD ticks that do not expire.
  f1_delay_counter #(
    .DW(DW)
  ) u_hold_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cnt_load),
    .load_value(delay_q),
    .en        (cnt_en),
    .zero      (cnt_zero)
  );

  // Next-state, next-pattern and go decode; abort overrides everything.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave a value undriven (no latches).
    state_next = state;
    data_next  = data_out;
    go_next    = 1'b0;
    delay_next = delay_q;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;

    if (abort) begin
      state_next = IDLE;
      data_next  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          data_next = '0;
          // The trigger is sampled every edge, independent of the tick.
          if (trigger) begin
            state_next = FILL;
            delay_next = delay_in;
          end
        end

        FILL: begin
          if (en) begin
            data_next = {data_out[N_LIGHTS-2:0], 1'b1};
            // The lamp below the MSB already lit means this tick completes
            // the pattern, so the hold count starts now.
            if (data_out[N_LIGHTS-2]) begin
              state_next = HOLD;
              cnt_load   = 1'b1;
            end
          end
        end

        HOLD: begin
          if (en) begin
            if (cnt_zero) begin
              data_next = '0;
              go_next   = 1'b1;
              if (loop) begin
                state_next = FILL;
                delay_next = delay_in;
              end else begin
                state_next = IDLE;
              end
            end else begin
              cnt_en = 1'b1;
            end
          end
        end

        default: begin
          state_next = IDLE;
          data_next  = '0;
        end
      endcase
    end
  end

  // State, pattern, go pulse and latched delay registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_out <= '0;
      go       <= 1'b0;
      delay_q  <= '0;
    end else begin
      state    <= state_next;
      data_out <= data_next;
      go       <= go_next;
      delay_q  <= delay_next;
    end
  end

  // Busy is a pure decode of the state, so it falls together with go.
  assign busy = (state != IDLE);

endmodule : f1_light_seq

// File: tb/tb_f1_light_seq.sv
// Directed bench for f1_light_seq (N_LIGHTS=8, DW=8): a table of per-edge
// input/expected-output records plus a hand-written gated-tick sequence.
module tb_f1_light_seq;

  typedef struct {
    string      tag;
    logic       rst_n;
    logic       en;
    logic       trigger;
    logic       abort;
    logic       loop;
    logic [7:0] delay_in;
    logic [7:0] exp_data;
    logic       exp_busy;
    logic       exp_go;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       trigger;
  logic       abort;
  logic       loop;
  logic [7:0] delay_in;
  logic [7:0] data_out;
  logic       busy;
  logic       go;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];

  // Fill pattern after each of the eight fill ticks.
  logic [7:0] fp [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

  f1_light_seq #(
    .N_LIGHTS(8),
    .DW      (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .trigger (trigger),
    .abort   (abort),
    .loop    (loop),
    .delay_in(delay_in),
    .data_out(data_out),
    .busy    (busy),
    .go      (go)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input string tag, input logic r, input logic e, input logic t,
                     input logic a, input logic l, input logic [7:0] d,
                     input logic [7:0] xd, input logic xb, input logic xg);
    vec_t v;
    v.tag = tag; v.rst_n = r; v.en = e; v.trigger = t; v.abort = a; v.loop = l;
    v.delay_in = d; v.exp_data = xd; v.exp_busy = xb; v.exp_go = xg;
    vecs.push_back(v);
  endtask

  // Drive one set of inputs, clock one edge, sample 1 ns later.
  task automatic step(input logic r, input logic e, input logic t, input logic a,
                      input logic l, input logic [7:0] d);
    rst_n = r; en = e; trigger = t; abort = a; loop = l; delay_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] xd, input logic xb,
                            input logic xg);
    check({tag, ".data"}, 32'(data_out), 32'(xd));
    check({tag, ".busy"}, 32'(busy), 32'(xb));
    check({tag, ".go"}, 32'(go), 32'(xg));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; trigger = 1'b0; abort = 1'b0; loop = 1'b0; delay_in = 8'h00;

    // Reset dominates en and trigger; no progress afterwards without trigger.
    for (int i = 0; i < 3; i++) add("rst", 0, 1, 1, 0, 0, 8'h05, 8'h00, 0, 0);
    for (int i = 0; i < 2; i++) add("rst_rel", 1, 1, 0, 0, 0, 8'h05, 8'h00, 0, 0);

    // Basic sequence, delay 3; trigger and delay_in changes during fill ignored.
    add("b_trig", 1, 1, 1, 0, 0, 8'd3, 8'h00, 1, 0);
    for (int k = 0; k < 8; k++)
      add("b_fill", 1, 1, (k == 2), 0, 0, (k >= 4) ? 8'd9 : 8'd3, fp[k], 1, 0);
    for (int i = 0; i < 3; i++) add("b_hold", 1, 1, 0, 0, 0, 8'd9, 8'hFF, 1, 0);
    add("b_out", 1, 1, 0, 0, 0, 8'd9, 8'h00, 0, 1);
    add("b_idle", 1, 1, 0, 0, 0, 8'd9, 8'h00, 0, 0);

    // Abort at 0x1F.
    add("a_trig", 1, 1, 1, 0, 0, 8'd3, 8'h00, 1, 0);
    for (int k = 0; k < 5; k++) add("a_fill", 1, 1, 0, 0, 0, 8'd3, fp[k], 1, 0);
    add("a_abort", 1, 1, 0, 1, 0, 8'd3, 8'h00, 0, 0);
    add("a_after", 1, 1, 0, 0, 0, 8'd3, 8'h00, 0, 0);
    // Trigger together with abort in IDLE stays IDLE.
    add("a_trig_abort", 1, 1, 1, 1, 0, 8'd3, 8'h00, 0, 0);
    add("a_still_idle", 1, 1, 0, 0, 0, 8'd3, 8'h00, 0, 0);
    // Abort on the expiry tick suppresses go.
    add("x_trig", 1, 0, 1, 0, 0, 8'd0, 8'h00, 1, 0);
    for (int k = 0; k < 8; k++) add("x_fill", 1, 1, 0, 0, 0, 8'd0, fp[k], 1, 0);
    add("x_abort_exp", 1, 1, 0, 1, 0, 8'd0, 8'h00, 0, 0);
    add("x_after", 1, 1, 0, 0, 0, 8'd0, 8'h00, 0, 0);

    // Loop mode: delay 2, changed to 5 during hold, latched at restart.
    add("l_trig", 1, 1, 1, 0, 1, 8'd2, 8'h00, 1, 0);
    for (int k = 0; k < 8; k++) add("l_fill1", 1, 1, 0, 0, 1, 8'd2, fp[k], 1, 0);
    for (int i = 0; i < 2; i++) add("l_hold1", 1, 1, 0, 0, 1, 8'd5, 8'hFF, 1, 0);
    add("l_out1", 1, 1, 0, 0, 1, 8'd5, 8'h00, 1, 1);
    for (int k = 0; k < 8; k++) add("l_fill2", 1, 1, 0, 0, 1, 8'd1, fp[k], 1, 0);
    for (int i = 0; i < 5; i++) add("l_hold2", 1, 1, 0, 0, 0, 8'd1, 8'hFF, 1, 0);
    add("l_out2", 1, 1, 0, 0, 0, 8'd1, 8'h00, 0, 1);
    add("l_idle", 1, 1, 0, 0, 0, 8'd1, 8'h00, 0, 0);

    // Reset mid-hold, then a fresh start from 0x01.
    add("r_trig", 1, 1, 1, 0, 0, 8'd4, 8'h00, 1, 0);
    for (int k = 0; k < 8; k++) add("r_fill", 1, 1, 0, 0, 0, 8'd4, fp[k], 1, 0);
    add("r_hold", 1, 1, 0, 0, 0, 8'd4, 8'hFF, 1, 0);
    add("r_rst", 0, 1, 0, 0, 0, 8'd4, 8'h00, 0, 0);
    add("r_rel", 1, 1, 0, 0, 0, 8'd4, 8'h00, 0, 0);
    add("r_trig2", 1, 0, 1, 0, 0, 8'd0, 8'h00, 1, 0);
    for (int k = 0; k < 8; k++) add("r_fill2", 1, 1, 0, 0, 0, 8'd0, fp[k], 1, 0);
    add("r_out2", 1, 1, 0, 0, 0, 8'd0, 8'h00, 0, 1);
    add("r_idle", 1, 1, 0, 0, 0, 8'd0, 8'h00, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].en, vecs[i].trigger, vecs[i].abort, vecs[i].loop,
           vecs[i].delay_in);
      expect_out(vecs[i].tag, vecs[i].exp_data, vecs[i].exp_busy, vecs[i].exp_go);
    end

    // Zero delay with a tick every 4th clock: pattern holds between ticks,
    // 0xFF lasts one tick and go is exactly one clock wide.
    step(1, 0, 1, 0, 0, 8'd0);
    expect_out("g_trig", 8'h00, 1, 0);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 3; j++) begin
        step(1, 0, 0, 0, 0, 8'd0);
        expect_out("g_gap", (k == 0) ? 8'h00 : fp[k-1], 1, 0);
      end
      step(1, 1, 0, 0, 0, 8'd0);
      expect_out("g_tick", fp[k], 1, 0);
    end
    for (int j = 0; j < 3; j++) begin
      step(1, 0, 0, 0, 0, 8'd0);
      expect_out("g_hold_gap", 8'hFF, 1, 0);
    end
    step(1, 1, 0, 0, 0, 8'd0);
    expect_out("g_out", 8'h00, 0, 1);
    for (int j = 0; j < 2; j++) begin
      step(1, 0, 0, 0, 0, 8'd0);
      expect_out("g_go_low", 8'h00, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_f1_light_seq

// File: doc/f1_light_seq.md
# f1_light_seq

Parametrised F1 start-light sequencer: on a trigger, lights fill one per tick from LSB to MSB, hold all-on for a programmable number of ticks, then go dark and emit a one-cycle `go` pulse. It sits between the tick generator (`en`) and the light driver / reaction-timer logic. It generalises the fixed 8-light free-running sequence with:

- configurable light count and delay width
- a triggered start
- a programmable hold delay
- an abort input
- a loop mode

## Interface
Parameters:
- `N_LIGHTS`, 8, number of lights (≥2)
- `DW`, 8, width of hold-delay value

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: synchronous, active-low reset
- `en` in 1: tick enable; sequence advances only on edges where `en`=1
- `trigger` in 1: start request, sampled every edge while IDLE (independent of `en`)
- `abort` in 1: synchronous cancel
- `loop` in 1: 1 = restart FILL after lights-out instead of returning to IDLE
- `delay_in` in DW: hold ticks, latched on start and on each loop restart
- `data_out` out N_LIGHTS: registered light pattern
- `busy` out 1: 1 in FILL or HOLD
- `go` out 1: registered one-cycle lights-out pulse

## Operation
- States: IDLE, FILL, HOLD.
- Reset (`rst_n`=0 at edge) forces:
  - state=IDLE
  - `data_out`=0, `go`=0, `busy`=0
  - counter=0, `delay_q`=0
- Reset wins over every other input.

IDLE:
- `data_out`=0.
- `trigger`=1 → FILL, `delay_q`<=`delay_in`. `data_out` is unchanged on this edge.

FILL, on an `en` edge:
- `data_out` <= {`data_out`[N-2:0],1}.
- If `data_out`[N-2]==1 before the edge (pattern becomes all-ones) → HOLD, counter<=`delay_q`.

HOLD, on an `en` edge:
- If counter==0: `data_out`<=0 and `go`<=1.
  - `loop`=0 → IDLE.
  - `loop`=1 → FILL, `delay_q`<=`delay_in`.
- Else counter<=counter-1.

`go` behaviour:
- Deasserts on the next edge.
- Is never asserted for two consecutive cycles.

`abort`=1 at any edge outside reset:
- state=IDLE, `data_out`=0, `go`=0.
- Takes priority over `trigger`, `en` and counter expiry.

Other rules:
- `trigger` is ignored while `busy`.
- `delay_in` changes are ignored except at the latch points above.
- No `en` → no progress; the state and pattern are held indefinitely.
- Counter is DW bits and only decrements from non-zero, so it never wraps.

## Timing
- Trigger edge to first light: 1 `en` tick after entering FILL.
- All-on reached after N_LIGHTS ticks in FILL.
- Lights out after a further `delay_q`+1 ticks; `go` is high in the cycle following that edge.
- `delay_in`=0 → lights out on the first HOLD tick.
- `busy` is combinational from state; it drops in the same cycle `go` rises (`loop`=0).
- In loop mode `busy` stays 1 continuously; `data_out` is 0 for exactly one tick between sequences.
- Simultaneous `trigger` and `abort` in IDLE: remain IDLE.
- Abort in the same cycle as counter expiry: no `go`.

## Structure
- Package `f1_pkg`: state enum `f1_state_t` {IDLE, FILL, HOLD}, default `N_LIGHTS`/`DW` localparams.
- Sub-module `f1_delay_counter`:
  - DW-bit load/decrement-on-`en` counter with a `zero` flag.
  - Instantiated once for the HOLD count.
- Top holds the state register, pattern shift register and `go` register.

## Test plan
All scenarios use N=8, DW=8.
- Reset: `rst_n`=0 with `en`=1 and `trigger`=1 → `data_out`=0x00, `go`=0, `busy`=0; no progress until `rst_n`=1.
- Basic sequence: `delay_in`=3, trigger, `en` every cycle → `data_out` 0x01,0x03,…,0xFF on ticks 1–8, 0xFF held ticks 9–11, 0x00 at tick 12 with single-cycle `go`, IDLE after.
- Zero delay and gated `en`: `delay_in`=0, `en` every 4th cycle → 0xFF lasts one tick, `go` exactly one clock wide, pattern holds between ticks.
- Abort: abort at pattern 0x1F → next cycle 0x00, IDLE, no `go`; trigger while busy → ignored (pattern continues).
- Loop mode: `loop`=1, `delay_in`=2 then changed to 5 during HOLD → first hold 3 ticks, one tick 0x00 with `go`, refill, second hold 6 ticks.
- Reset mid-HOLD: `rst_n`=0 while 0xFF → 0x00, IDLE, counter cleared; a new trigger restarts from 0x01.
